wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage directly downstream of the memory unit. It latches each instruction's memory-stage results (load data, ALU result, return address) into a MEM/WB pipeline register, selects the writeback value, and commits it to the 16-entry architectural register file one edge later. It provides two combinational read ports with bypass from the pending writeback, plus a retired-instruction counter.

Parameters:
NREG, 16, number of architectural registers; register index width is log2(NREG) = 4
RA_IDX, 15, register written by call instructions (return address)
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  memory stage presents a valid instruction
in_ready  out  1  stage can accept; equals !hold
hold  in  1  downstream stall; freezes the MEM/WB latch and register-file write
isLd  in  1  instruction is a load; writeback value is ldResult
isCall  in  1  instruction is a call; writes pc+4 to RA_IDX
isWb  in  1  instruction writes a register
rd  in  4  destination register index (ignored when isCall=1)
alu_Res  in  32  ALU result from the memory stage
ldResult  in  32  load data from the memory unit
pc  in  32  instruction PC
rs1_addr  in  4  read port 1 index
rs2_addr  in  4  read port 2 index
rs1_data  out  32  read port 1 data, bypassed
rs2_data  out  32  read port 2 data, bypassed
wb_valid  out  1  MEM/WB latch holds a committing write
wb_rd  out  4  latched destination index
wb_data  out  32  latched writeback value
retired_count  out  32  number of committed instructions

Behaviour:
- Reset (async, rst_n=0): all registers in the file = 0; wb_valid=0; wb_rd=0; wb_data=0; retired_count=0. Takes effect immediately, mid-operation included. A pending write is discarded, not committed.
- Accept: at an edge with in_valid=1 and hold=0, the latch loads:
  - wb_valid = isWb | isCall
  - wb_rd = isCall ? RA_IDX : rd
  - wb_data = isCall ? pc+4 (mod 2^32) : isLd ? ldResult : alu_Res
  - Priority: isCall > isLd > ALU.
- Bubble: at an edge with in_valid=0 and hold=0, wb_valid becomes 0. wb_rd and wb_data keep their old values.
- Commit: at every edge with hold=0 and wb_valid=1, regfile[wb_rd] <= wb_data and retired_count increments by 1. The count wraps from 0xFFFFFFFF to 0. A newly accepted instruction loads into the latch on the same edge, so throughput is 1 instruction per cycle.
- Hold: while hold=1 the latch, the register file and retired_count are all frozen, and in_ready=0. in_valid is ignored. Upstream must keep its outputs stable until in_ready=1.
- Latency: values accepted at edge N are visible on wb_* after edge N and written into the file at the first edge ≥N+1 with hold=0.
- Read ports (combinational): rsX_data = (wb_valid && wb_rd==rsX_addr) ? wb_data : regfile[rsX_addr].
  - The bypass applies during hold as well.
  - Both ports may read the same index.
- No hardwired-zero register: r0 is writable like any other register.
- Inputs with isWb=0 and isCall=0 (e.g. stores, branches) produce wb_valid=0, no commit and no count increment.

Test Plan:
- Reset mid-stream: latch a write of 0xDEADBEEF to r3, assert rst_n=0 before the commit edge → r3 reads 0, wb_valid=0, retired_count=0.
- Load vs ALU select: isLd=1, ldResult=0x12345678, alu_Res=0x400, rd=5, then isLd=0, alu_Res=0x7, rd=6 → r5=0x12345678, r6=0x7, retired_count=2.
- Call: isCall=1, pc=0x100, rd=2, isWb=0 → r15=0x104 after commit, r2 unchanged. With pc=0xFFFFFFFC, r15=0x0.
- Bypass: accept a write of 0xA5A5A5A5 to r4 with rs1_addr=rs2_addr=4 → both ports return 0xA5A5A5A5 in the cycle after acceptance, before the commit edge.
- Hold: latch an r7 write, hold=1 for 3 cycles while in_valid toggles → in_ready=0, the file is unchanged, the bypass still shows the value, and exactly one commit happens after release.
- Non-writing op and wrap: isWb=0 store → no register changes and no count change. Preload retired_count to 0xFFFFFFFF (force) and commit once → count=0.

Source files
------------

// File: rtl/wb_if.sv
// Writeback-stage bus: memory-stage handshake and results, register-file
// read ports and the stage's observable latch/retire state.
//   master: memory stage / consumer side (drives instruction, reads results)
//   slave : wb_stage (accepts instruction, drives read data and status)
interface wb_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic          isLd;
  logic          isCall;
  logic          isWb;
  logic [AW-1:0] rd;
  logic [DW-1:0] alu_Res;
  logic [DW-1:0] ldResult;
  logic [DW-1:0] pc;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] retired_count;

  modport master (
    output in_valid, hold, isLd, isCall, isWb, rd, alu_Res, ldResult, pc,
           rs1_addr, rs2_addr,
    input  in_ready, rs1_data, rs2_data, wb_valid, wb_rd, wb_data, retired_count
  );

  modport slave (
    input  in_valid, hold, isLd, isCall, isWb, rd, alu_Res, ldResult, pc,
           rs1_addr, rs2_addr,
    output in_ready, rs1_data, rs2_data, wb_valid, wb_rd, wb_data, retired_count
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline latch, 16-entry register file with two
// bypassed combinational read ports, and a retired-instruction counter.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - wb_if slave: instruction in (in_valid/in_ready/hold, isLd, isCall,
//           isWb, rd, alu_Res, ldResult, pc), read ports (rsX_addr/rsX_data),
//           status out (wb_valid, wb_rd, wb_data, retired_count)
module wb_stage #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned RA_IDX = 15,
  parameter int unsigned DW     = 32
) (
  input logic clk,
  input logic rst_n,
  wb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [DW-1:0] rf_q [NREG];
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [DW-1:0] count_q, count_d;
  logic          commit;

  // Everything is frozen under hold; the pending write commits on the same
  // edge that the next instruction is latched.
  assign commit = !bus.hold && wb_valid_q;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    count_d    = count_q;
    if (!bus.hold) begin
      wb_valid_d = bus.in_valid && (bus.isWb || bus.isCall);
      if (bus.in_valid) begin
        wb_rd_d = bus.isCall ? AW'(RA_IDX) : bus.rd;
        if (bus.isCall) begin
          wb_data_d = bus.pc + DW'(4);
        end else if (bus.isLd) begin
          wb_data_d = bus.ldResult;
        end else begin
          wb_data_d = bus.alu_Res;
        end
      end
      if (wb_valid_q) begin
        count_d = count_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      count_q    <= count_d;
      if (commit) begin
        rf_q[wb_rd_q] <= wb_data_q;
      end
    end
  end

  // Read ports see the pending write even while held.
  assign bus.rs1_data = (wb_valid_q && wb_rd_q == bus.rs1_addr) ? wb_data_q : rf_q[bus.rs1_addr];
  assign bus.rs2_data = (wb_valid_q && wb_rd_q == bus.rs2_addr) ? wb_data_q : rf_q[bus.rs2_addr];

  assign bus.in_ready      = !bus.hold;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.retired_count = count_q;
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  wb_if bus ();

  wb_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic call, input logic wb, input logic [3:0] r,
                       input logic [31:0] alu, input logic [31:0] ldv, input logic [31:0] p);
    bus.in_valid = 1'b1;
    bus.isLd     = ld;
    bus.isCall   = call;
    bus.isWb     = wb;
    bus.rd       = r;
    bus.alu_Res  = alu;
    bus.ldResult = ldv;
    bus.pc       = p;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    bus.isLd     = 1'b0;
    bus.isCall   = 1'b0;
    bus.isWb     = 1'b0;
    bus.rd       = '0;
    bus.alu_Res  = '0;
    bus.ldResult = '0;
    bus.pc       = '0;
    bus.rs1_addr = 4'd3;
    bus.rs2_addr = 4'd0;
    tick();
    tick();

    // Reset state
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_count", bus.retired_count, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Reset mid-stream discards a pending write
    issue(1'b0, 1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("mid_latched_valid", 32'(bus.wb_valid), 32'd1);
    chk("mid_latched_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("mid_bypass_r3", bus.rs1_data, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(bus.wb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_r3_zero", bus.rs1_data, 32'd0);
    chk("mid_count_zero", bus.retired_count, 32'd0);

    // Load vs ALU select, back to back
    issue(1'b1, 1'b0, 1'b1, 4'd5, 32'h400, 32'h1234_5678, 32'h0);
    tick();
    chk("ld_wb_data", bus.wb_data, 32'h1234_5678);
    chk("ld_wb_rd", 32'(bus.wb_rd), 32'd5);
    issue(1'b0, 1'b0, 1'b1, 4'd6, 32'h7, 32'h1234_5678, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.rs1_addr = 4'd5;
    bus.rs2_addr = 4'd6;
    #1;
    chk("ld_r5", bus.rs1_data, 32'h1234_5678);
    chk("alu_r6", bus.rs2_data, 32'h7);
    chk("ld_count2", bus.retired_count, 32'd2);

    // Call writes pc+4 to r15, ignores rd
    issue(1'b0, 1'b1, 1'b0, 4'd2, 32'h55, 32'h66, 32'h100);
    tick();
    bus.in_valid = 1'b0;
    chk("call_wb_rd", 32'(bus.wb_rd), 32'd15);
    chk("call_wb_data", bus.wb_data, 32'h104);
    tick();
    bus.rs1_addr = 4'd15;
    bus.rs2_addr = 4'd2;
    #1;
    chk("call_r15", bus.rs1_data, 32'h104);
    chk("call_r2_untouched", bus.rs2_data, 32'd0);
    chk("call_count3", bus.retired_count, 32'd3);
    issue(1'b1, 1'b1, 1'b1, 4'd2, 32'h55, 32'h66, 32'hFFFF_FFFC);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("call_wrap_r15", bus.rs1_data, 32'd0);
    chk("call_r2_still", bus.rs2_data, 32'd0);

    // Bypass before commit, both ports on one index
    issue(1'b0, 1'b0, 1'b1, 4'd4, 32'hA5A5_A5A5, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    bus.rs1_addr = 4'd4;
    bus.rs2_addr = 4'd4;
    #1;
    chk("byp_rs1", bus.rs1_data, 32'hA5A5_A5A5);
    chk("byp_rs2", bus.rs2_data, 32'hA5A5_A5A5);
    chk("byp_file_r4", dut.rf_q[4], 32'd0);
    tick();
    chk("byp_committed_r4", bus.rs1_data, 32'hA5A5_A5A5);
    chk("byp_count5", bus.retired_count, 32'd5);

    // Hold freezes latch, file and count; bypass still visible
    issue(1'b0, 1'b0, 1'b1, 4'd7, 32'h77, 32'h0, 32'h0);
    tick();
    bus.hold     = 1'b1;
    bus.rs1_addr = 4'd7;
    issue(1'b0, 1'b0, 1'b1, 4'd8, 32'h88, 32'h0, 32'h0);
    #1;
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i % 2 == 1);
      tick();
      chk("hold_count", bus.retired_count, 32'd5);
      chk("hold_bypass_r7", bus.rs1_data, 32'h77);
      chk("hold_file_r7", dut.rf_q[7], 32'd0);
    end
    chk("hold_wb_rd", 32'(bus.wb_rd), 32'd7);
    bus.hold     = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("release_count6", bus.retired_count, 32'd6);
    chk("release_r7", dut.rf_q[7], 32'h77);
    bus.rs2_addr = 4'd8;
    tick();
    chk("release_one_commit", bus.retired_count, 32'd6);
    chk("release_r8_untouched", bus.rs2_data, 32'd0);

    // Store-like op: no write, no count
    issue(1'b0, 1'b0, 1'b0, 4'd9, 32'h99, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("store_wb_valid", 32'(bus.wb_valid), 32'd0);
    tick();
    bus.rs1_addr = 4'd9;
    #1;
    chk("store_r9", bus.rs1_data, 32'd0);
    chk("store_count", bus.retired_count, 32'd6);

    // r0 is an ordinary register
    issue(1'b0, 1'b0, 1'b1, 4'd0, 32'hCAFE, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("r0_written", dut.rf_q[0], 32'hCAFE);

    // Counter wrap
    bus.hold = 1'b1;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    chk("wrap_preload", bus.retired_count, 32'hFFFF_FFFF);
    issue(1'b0, 1'b0, 1'b1, 4'd10, 32'h1, 32'h0, 32'h0);
    bus.hold = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("wrap_before_commit", bus.retired_count, 32'hFFFF_FFFF);
    tick();
    bus.rs1_addr = 4'd10;
    #1;
    chk("wrap_count0", bus.retired_count, 32'd0);
    chk("wrap_r10", bus.rs1_data, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
